// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard FSM states, register-index type and the stall lengths
// used by the hazard controller.
package cpu_types_pkg;
    localparam int REGIDX_W = 5;
    typedef logic [REGIDX_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    localparam int LD_USE_LEN  = 1;
    localparam int BR_LOAD_LEN = 2;
endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier: flags a hazard the forwarding unit cannot cover
// and reports how many cycles the ID instruction must be held.
module hazard_detect
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_regwr_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_memread_i,
    output logic             hz_o,
    output logic [1:0]       len_o
);
    logic dep_ex, dep_mem;
    logic ld_use, br_alu, br_ld, br_mem;

    // r0 is hardwired to zero, so a write to it never creates a dependence.
    assign dep_ex  = ex_regwr_i && (ex_rd_i != '0) &&
                     ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
    assign dep_mem = mem_memread_i && (mem_rd_i != '0) &&
                     ((mem_rd_i == id_rs_i) || (id_uses_rt_i && (mem_rd_i == id_rt_i)));

    assign ld_use = ex_memread_i && dep_ex && !id_branch_i;
    assign br_alu = id_branch_i && dep_ex && !ex_memread_i;
    assign br_ld  = id_branch_i && dep_ex && ex_memread_i;
    assign br_mem = id_branch_i && dep_mem;

    assign hz_o  = ld_use || br_alu || br_ld || br_mem;
    // The longest overlapping hazard wins.
    assign len_o = br_ld ? 2'(BR_LOAD_LEN) : 2'(LD_USE_LEN);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: PC and latch enables/flushes, stall FSM,
// sticky halt and stall/flush performance counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             ex_pcsrc,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_STALL = STALL;
    localparam logic [1:0] ST_HALT  = HALT;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic [4:0]       en;
    logic [3:0]       fl;
    logic             hz, dwait, flush_ev, stall_ev;
    logic [1:0]       hz_len;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .id_branch_i   (id_branch),
        .ex_rd_i       (ex_rd),
        .ex_regwr_i    (ex_regwr),
        .ex_memread_i  (ex_memread),
        .mem_rd_i      (mem_rd),
        .mem_memread_i (mem_memread),
        .hz_o          (hz),
        .len_o         (hz_len)
    );

    assign dwait = (mem_memread || mem_memwrite) && !dhit;

    always_comb begin
        en       = '1;
        fl       = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_ev = 1'b0;
        if (!nRST) begin
            en = '0;
        end else if (state_q == ST_HALT || mem_halt) begin
            en      = '0;
            state_d = ST_HALT;
        end else if (dwait) begin
            // EX is frozen too, so a resolved branch there simply waits with it.
            en = '0;
            fl = 4'b0001;
        end else if (ex_pcsrc) begin
            fl       = 4'b1100;
            state_d  = ST_RUN;
            cnt_d    = '0;
            flush_ev = 1'b1;
        end else if (state_q == ST_STALL || hz) begin
            en = 5'b00111;
            fl = 4'b0100;
            if (state_q == ST_STALL) begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = ST_RUN;
            end else if (hz_len == 2'(BR_LOAD_LEN)) begin
                state_d = ST_STALL;
                cnt_d   = 2'(BR_LOAD_LEN - 1);
            end
        end else if (!ihit) begin
            en = 5'b01111;
            fl = 4'b1000;
        end
    end

    assign stall_ev = !en[4] && (state_q != ST_HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_ev) stall_q <= stall_q + CNT_W'(1);
            if (flush_ev) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en}          = en;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush}     = fl;
    assign halt         = (state_q == ST_HALT);
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, every cycle
// compared against a cycle-count model of the hazard rules.
module tb_hazard_ctrl;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_uses_rt, id_branch, ex_regwr, ex_memread;
    logic        mem_memread, mem_memwrite, ex_pcsrc, ihit, dhit, mem_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [31:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: sticky halt flag, forced stall cycles still owed, counters.
    bit          m_halted;
    int          m_left;
    logic [31:0] m_stall, m_flush;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .ex_pcsrc(ex_pcsrc), .ihit(ihit), .dhit(dhit), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] rd);
        return (rd != 0) && (rd == id_rs || (id_uses_rt && rd == id_rt));
    endfunction

    // Cycles the ID instruction must be held, 0 when forwarding suffices.
    function automatic int need_stall();
        int  n = 0;
        bit  on_ex  = ex_regwr && reads(ex_rd);
        bit  on_mem = mem_memread && reads(mem_rd);
        if (!id_branch && ex_memread && on_ex) n = 1;
        if (id_branch && on_ex) n = ex_memread ? 2 : 1;
        if (id_branch && on_mem && n < 1) n = 1;
        return n;
    endfunction

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0;
        ex_rd = 0; ex_regwr = 0; ex_memread = 0;
        mem_rd = 0; mem_memread = 0; mem_memwrite = 0;
        ex_pcsrc = 0; ihit = 1; dhit = 1; mem_halt = 0;
    endtask

    // One clock: check outputs at the negedge, advance the model, return at posedge+1.
    task automatic tick();
        logic [8:0] e;
        int         n;
        @(negedge CLK);
        if (!nRST) begin
            m_halted = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end
        n = need_stall();
        if (!nRST)                                   e = 9'b00000_0000;
        else if (m_halted || mem_halt)               e = 9'b00000_0000;
        else if ((mem_memread || mem_memwrite) && !dhit) e = 9'b00000_0001;
        else if (ex_pcsrc)                           e = 9'b11111_1100;
        else if (m_left > 0 || n > 0)                e = 9'b00111_0100;
        else if (!ihit)                              e = 9'b01111_1000;
        else                                         e = 9'b11111_0000;
        chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush}, e);
        chk("halt", halt, m_halted);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_events", flush_events, m_flush);
        if (nRST) begin
            if (!e[8] && !m_halted) m_stall++;
            if (m_halted || mem_halt) m_halted = 1;
            else if ((mem_memread || mem_memwrite) && !dhit) ;
            else if (ex_pcsrc) begin m_left = 0; m_flush++; end
            else if (m_left > 0) m_left--;
            else if (n > 0) m_left = n - 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        nRST = 0;
        tick();
        nRST = 1;
    endtask

    initial begin
        idle();
        nRST = 0;
        m_halted = 0; m_left = 0; m_stall = 0; m_flush = 0;
        tick();
        chk("rst_pc_en", pc_en, 1'b0);
        nRST = 1;
        tick();

        // Load-use: a single bubble.
        do_reset();
        ex_memread = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8;
        tick();
        idle(); tick();
        chk("lu_total", stall_cycles, 32'd1);

        // Branch on a load in EX: two bubbles.
        do_reset();
        id_branch = 1; id_uses_rt = 1; id_rt = 9; ex_memread = 1; ex_regwr = 1; ex_rd = 9;
        tick();
        ex_memread = 0; ex_regwr = 0; ex_rd = 0;
        tick();
        idle(); tick();
        chk("bl_total", stall_cycles, 32'd2);

        // r0 never stalls.
        do_reset();
        ex_memread = 1; ex_regwr = 1; ex_rd = 0; id_rs = 0;
        tick();
        chk("r0_total", stall_cycles, 32'd0);

        // Memory wait in the middle of a branch-on-load stall.
        do_reset();
        id_branch = 1; id_uses_rt = 1; id_rt = 9; ex_memread = 1; ex_regwr = 1; ex_rd = 9;
        tick();
        ex_memread = 0; ex_regwr = 0; ex_rd = 0; mem_memread = 1; dhit = 0;
        repeat (3) tick();
        dhit = 1;
        tick();
        idle(); tick();
        chk("dw_total", stall_cycles, 32'd5);

        // Taken branch outranks a load-use hazard.
        do_reset();
        ex_memread = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8; ex_pcsrc = 1;
        tick();
        idle(); tick();
        chk("fl_events", flush_events, 32'd1);
        chk("fl_stalls", stall_cycles, 32'd0);

        // Reset in the middle of a stall leaves nothing pending.
        do_reset();
        id_branch = 1; id_uses_rt = 1; id_rt = 9; ex_memread = 1; ex_regwr = 1; ex_rd = 9;
        tick();
        idle(); nRST = 0; tick();
        nRST = 1; tick();
        chk("rs_pc_en", pc_en, 1'b1);

        // Sticky halt, cleared only by reset.
        do_reset();
        mem_halt = 1;
        tick();
        mem_halt = 0;
        repeat (3) tick();
        chk("halt_sticky", halt, 1'b1);
        nRST = 0;
        tick();
        chk("halt_rst", halt, 1'b0);
        chk("halt_rst_cnt", stall_cycles, 32'd0);
        nRST = 1;

        // Random traffic on a small register pool to force collisions.
        for (int i = 0; i < 4000; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom);
            id_branch    = ($urandom_range(0, 2) == 0);
            ex_regwr     = 1'($urandom);
            ex_memread   = 1'($urandom);
            mem_memread  = ($urandom_range(0, 3) == 0);
            mem_memwrite = ($urandom_range(0, 5) == 0);
            ex_pcsrc     = ($urandom_range(0, 9) == 0);
            ihit         = ($urandom_range(0, 6) != 0);
            dhit         = ($urandom_range(0, 4) != 0);
            mem_halt     = ($urandom_range(0, 199) == 0);
            nRST         = !(m_halted && $urandom_range(0, 7) == 0) &&
                           ($urandom_range(0, 499) != 0);
            tick();
        end
        nRST = 1;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS core; the counterpart to the forwarding unit, covering every hazard that forwarding cannot resolve.
- Produces PC enable and per-latch enable/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle load-use and branch-operand stalls with a registered stall FSM.
- Handles memory-wait freezes, taken-branch flushes and sticky halt, and keeps stall/flush performance counters.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 32, width of performance counters.

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_W  source registers of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, branch, store)
- id_branch  in  1  ID instruction is BEQ/BNE/JR (compares/reads operands in ID)
- ex_rd  in  REG_W  destination register of instruction in EX
- ex_regwr, ex_memread  in  1  EX instruction writes reg / is a load
- mem_rd  in  REG_W  destination register in MEM
- mem_memread, mem_memwrite  in  1  MEM stage load/store request
- ex_pcsrc  in  1  taken branch/jump resolved in EX
- ihit, dhit  in  1  instruction/data memory done
- mem_halt  in  1  HALT reached MEM stage
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  latch enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  insert bubble
- halt  out  1  sticky halt
- stall_cycles, flush_events  out  CNT_W  performance counters

Behaviour:
- Reset (async, nRST=0): state=RUN, cnt=0, halt=0, both counters=0. While in reset, all enables=0 and all flushes=0.
- FSM states:
  - RUN
  - STALL: cnt holds remaining extra stall cycles, 2-bit.
  - HALT
- Hazard classes, evaluated combinationally from inputs; register 0 never creates a dependence:
  - dep_ex = ex_regwr & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))
  - dep_mem = mem_memread & mem_rd!=0 & (same compare against mem_rd)
  - load-use: ex_memread & dep_ex & !id_branch → stall length 1.
  - branch-on-ALU: id_branch & dep_ex & !ex_memread → length 1.
  - branch-on-load: id_branch & dep_ex & ex_memread → length 2.
  - branch-on-MEM-load: id_branch & dep_mem → length 1.
- Priority per cycle, highest first:
  1. HALT state or mem_halt:
     - All enables=0, all flushes=0.
     - halt=1 from the next edge; HALT is sticky until reset.
  2. dwait = (mem_memread|mem_memwrite) & !dhit:
     - All enables=0, memwb_flush=1, other flushes=0.
     - FSM and cnt hold. Any pending ex_pcsrc persists because EX is frozen, so no latch is needed.
  3. ex_pcsrc:
     - ifid_flush=1, idex_flush=1, all enables=1.
     - Any hazard from the discarded ID instruction is ignored.
     - If in STALL, go to RUN and set cnt=0.
     - flush_events += 1.
  4. stall (STALL state, or a hazard detected in RUN):
     - pc_en=0, ifid_en=0, idex_flush=1; remaining enables=1.
     - From RUN with length L: stall this cycle; if L=2 go to STALL with cnt=1, else stay in RUN.
     - In STALL: decrement cnt; go to RUN when cnt reaches 0.
     - New hazards are not re-evaluated while in STALL.
  5. !ihit: pc_en=0, ifid_flush=1, all other enables=1.
  6. Otherwise: all enables=1, flushes=0.
- stall_cycles increments in every cycle where pc_en=0 and state≠HALT, including dwait and iwait. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-stall or mid-halt returns to RUN immediately; no pending state survives.
- Outputs are combinational from state plus inputs. Zero-cycle latency from hazard to control.

Decomposition:
- Shared package cpu_types_pkg gains:
  - hz_state_t enum {RUN, STALL, HALT}
  - typedef regbits_t (logic [REG_W-1:0])
  - localparams LD_USE_LEN=1, BR_LOAD_LEN=2
- One natural sub-module: hazard_detect, purely combinational. It produces the hazard-present flag and stall length L from the register compares.
- The FSM, priority mux and counters stay in hazard_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_regwr=1, ex_rd=8, id_rs=8, ihit=dhit=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal; stall_cycles=1.
- Branch-on-load: id_branch=1, id_rt=9, id_uses_rt=1, ex_memread=1, ex_rd=9 → exactly 2 stall cycles (STALL entered with cnt=1), then RUN.
- Register 0: ex_memread=1, ex_rd=0, id_rs=0 → no stall; all enables=1.
- Dwait inside stall: in STALL with cnt=1, hold mem_memread=1, dhit=0 for 3 cycles → all enables=0, memwb_flush=1, cnt stays 1. After dhit=1, one more stall cycle, then RUN; stall_cycles=5 total.
- Flush beats hazard: ex_pcsrc=1 together with a load-use hazard → ifid_flush=idex_flush=1, pc_en=1, state RUN, flush_events=1.
- Halt: mem_halt=1 → halt=1 next cycle and stays asserted with all enables=0; pulse nRST=0 → halt=0, counters=0.
